// File: rtl/conv1_calc.sv
// 5x5 convolution engine: weight/bias load FSM feeding a 3-stage multiply / row-sum / total pipeline.
// Result = floor((sum(pixel*weight) + bias) / 2^SHIFT), saturated to OUT_BITS signed.
module conv1_calc #(
    parameter int DATA_BITS   = 8,
    parameter int WEIGHT_BITS = 8,
    parameter int SHIFT       = 8,
    parameter int OUT_BITS    = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [25*DATA_BITS-1:0]       window_in,
    input  logic                          valid_in,
    input  logic                          w_load,
    input  logic signed [WEIGHT_BITS-1:0] w_data,
    input  logic                          b_load,
    input  logic signed [15:0]            b_data,
    output logic                          ready,
    output logic signed [OUT_BITS-1:0]    conv_out,
    output logic                          valid_out
);
    localparam int PROD_W = DATA_BITS + WEIGHT_BITS + 1;
    localparam int ROW_W  = PROD_W + 3;
    localparam int SUM_W  = (PROD_W + 5 > 17) ? PROD_W + 5 : 17;

    localparam logic signed [OUT_BITS-1:0] OUT_MAX = {1'b0, {(OUT_BITS-1){1'b1}}};
    localparam logic signed [OUT_BITS-1:0] OUT_MIN = {1'b1, {(OUT_BITS-1){1'b0}}};

    typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

    state_t                        state_q, state_d;
    logic [4:0]                    idx_q, idx_d, widx;
    logic signed [WEIGHT_BITS-1:0] weight_q [25];
    logic signed [15:0]            bias_q;
    logic                          accept;

    logic signed [PROD_W-1:0]      prod_q [25];
    logic signed [PROD_W-1:0]      prod_d [25];
    logic signed [ROW_W-1:0]       row_q [5];
    logic signed [ROW_W-1:0]       row_d [5];
    logic signed [SUM_W-1:0]       total, shifted;
    logic signed [OUT_BITS-1:0]    sat_d, conv_q;
    logic                          v1_q, v2_q, valid_q;
    logic [DATA_BITS-1:0]          px;

    // A weight write while in RUN always restarts the sequence at index 0.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        widx    = (state_q == RUN) ? '0 : idx_q;
        if (w_load) begin
            if (widx == 5'd24) begin
                state_d = RUN;
                idx_d   = '0;
            end else begin
                state_d = LOAD;
                idx_d   = widx + 5'd1;
            end
        end
    end

    assign accept = valid_in && (state_q == RUN) && !w_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            idx_q   <= '0;
            bias_q  <= '0;
            for (int unsigned k = 0; k < 25; k++) weight_q[k] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (w_load) weight_q[widx] <= w_data;
            if (b_load) bias_q <= b_data;
        end
    end

    always_comb begin
        px = '0;
        for (int unsigned k = 0; k < 25; k++) begin
            px        = window_in[k*DATA_BITS +: DATA_BITS];
            prod_d[k] = PROD_W'($signed({1'b0, px})) * PROD_W'(weight_q[k]);
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < 5; r++) begin
            row_d[r] = '0;
            for (int unsigned c = 0; c < 5; c++)
                row_d[r] = row_d[r] + ROW_W'(prod_q[r*5+c]);
        end
    end

    // Bias is taken from the live register here, so writes up to edge t+1 are seen.
    always_comb begin
        total = SUM_W'(bias_q);
        for (int unsigned r = 0; r < 5; r++)
            total = total + SUM_W'(row_q[r]);
        shifted = total >>> SHIFT;
        if (shifted > SUM_W'(OUT_MAX))
            sat_d = OUT_MAX;
        else if (shifted < SUM_W'(OUT_MIN))
            sat_d = OUT_MIN;
        else
            sat_d = shifted[OUT_BITS-1:0];
    end

    always_ff @(posedge clk) begin
        if (accept) prod_q <= prod_d;
        if (v1_q)   row_q  <= row_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            valid_q <= 1'b0;
            conv_q  <= '0;
        end else begin
            v1_q    <= accept;
            v2_q    <= v1_q;
            valid_q <= v2_q;
            if (v2_q) conv_q <= sat_d;
        end
    end

    assign ready     = (state_q == RUN);
    assign conv_out  = conv_q;
    assign valid_out = valid_q;
endmodule

// File: tb/tb_conv1_calc.sv
// Directed self-checking bench for conv1_calc with default parameters (8b pixels/weights, SHIFT=8, 12b out).
module tb_conv1_calc;
    logic               clk = 1'b0;
    logic               rst;
    logic [199:0]       window_in;
    logic               valid_in;
    logic               w_load;
    logic signed [7:0]  w_data;
    logic               b_load;
    logic signed [15:0] b_data;
    logic               ready;
    logic signed [11:0] conv_out;
    logic               valid_out;

    int vectors = 0;
    int miscompares = 0;

    conv1_calc #(.DATA_BITS(8), .WEIGHT_BITS(8), .SHIFT(8), .OUT_BITS(12)) dut (
        .clk(clk), .rst(rst), .window_in(window_in), .valid_in(valid_in),
        .w_load(w_load), .w_data(w_data), .b_load(b_load), .b_data(b_data),
        .ready(ready), .conv_out(conv_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_weights(input logic signed [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            w_load = 1'b1;
            w_data = w;
            tick();
        end
        w_load = 1'b0;
    endtask

    task automatic set_bias(input logic signed [15:0] b);
        b_load = 1'b1;
        b_data = b;
        tick();
        b_load = 1'b0;
    endtask

    task automatic window_all(input logic [7:0] p);
        for (int k = 0; k < 25; k++) window_in[k*8 +: 8] = p;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid_in = 1'b0; w_load = 1'b0; w_data = '0;
        b_load = 1'b0; b_data = '0; window_in = '0;
        tick(); tick();
        rst = 1'b0;
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b want 0", ready); end
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid_out); end
        vectors++; if (conv_out !== 12'sd0) begin miscompares++; $display("FAIL reset_conv got %0d want 0", conv_out); end
    endtask

    task automatic test_partial_load();
        load_weights(8'sd1, 24);
        vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL partial_ready got %b want 0", ready); end
        window_all(8'd100);
        valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) valid_in = 1'b0;
            tick();
            vectors++; if (valid_out !== 1'b0 || ready !== 1'b0) begin
                miscompares++; $display("FAIL partial_idle[%0d] got valid=%b ready=%b want 0/0", i, valid_out, ready);
            end
        end
        load_weights(8'sd1, 1);
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL partial_25th_ready got %b want 1", ready); end
    endtask

    task automatic test_basic();
        logic signed [11:0] e;
        window_all(8'd100);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL basic_lat_t got %b want 0", valid_out); end
        tick();
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL basic_lat_t1 got %b want 0", valid_out); end
        tick();
        e = 12'sd9;  // 25*100 = 2500, >>8 = 9
        vectors++; if (valid_out !== 1'b1 || conv_out !== e) begin
            miscompares++; $display("FAIL basic_ones got valid=%b conv=%0d want 1/%0d", valid_out, conv_out, e);
        end
        tick(); tick();
        vectors++; if (valid_out !== 1'b0 || conv_out !== e) begin
            miscompares++; $display("FAIL basic_hold got valid=%b conv=%0d want 0/%0d", valid_out, conv_out, e);
        end
        for (int k = 0; k < 25; k++) window_in[k*8 +: 8] = 8'(k);
        set_bias(-16'sd1000);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick(); tick();
        e = -12'sd3;  // 300 - 1000 = -700, floor(-700/256) = -3
        vectors++; if (valid_out !== 1'b1 || conv_out !== e) begin
            miscompares++; $display("FAIL basic_ramp_negbias got valid=%b conv=%0d want 1/%0d", valid_out, conv_out, e);
        end
    endtask

    task automatic test_bias_timing();
        logic signed [11:0] e;
        window_all(8'd0);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        b_load = 1'b1; b_data = 16'sd512;
        tick();
        b_load = 1'b0;
        tick();
        e = 12'sd2;
        vectors++; if (valid_out !== 1'b1 || conv_out !== e) begin
            miscompares++; $display("FAIL bias_seen got valid=%b conv=%0d want 1/%0d", valid_out, conv_out, e);
        end
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        b_load = 1'b1; b_data = -16'sd512;
        tick();
        b_load = 1'b0;
        vectors++; if (valid_out !== 1'b1 || conv_out !== e) begin
            miscompares++; $display("FAIL bias_late got valid=%b conv=%0d want 1/%0d", valid_out, conv_out, e);
        end
    endtask

    task automatic test_saturate();
        load_weights(8'sd127, 25);
        set_bias(16'sd32767);
        window_all(8'd255);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick(); tick();
        vectors++; if (valid_out !== 1'b1 || conv_out !== 12'sd2047) begin
            miscompares++; $display("FAIL sat_pos got valid=%b conv=%0d want 1/2047", valid_out, conv_out);
        end
        load_weights(-8'sd128, 25);
        set_bias(16'sd0);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick(); tick();
        vectors++; if (valid_out !== 1'b1 || conv_out !== 12'h800) begin
            miscompares++; $display("FAIL sat_neg got valid=%b conv=%0d want 1/-2048", valid_out, conv_out);
        end
    endtask

    task automatic test_back_to_back();
        int exp_res [10] = '{0, 9, 19, 29, 39, 48, 58, 68, 78, 87};
        int pulses = 0;
        load_weights(8'sd4, 25);
        for (int n = 0; n < 14; n++) begin
            valid_in = (n < 10);
            rst      = (n == 10);
            window_all(8'(n * 25));
            tick();
            if (valid_out === 1'b1) pulses++;
            if (n >= 2 && n <= 9) begin
                vectors++; if (valid_out !== 1'b1 || conv_out !== 12'(exp_res[n-2])) begin
                    miscompares++; $display("FAIL b2b_out[%0d] got valid=%b conv=%0d want 1/%0d", n-2, valid_out, conv_out, exp_res[n-2]);
                end
            end else if (n >= 10) begin
                vectors++; if (valid_out !== 1'b0 || conv_out !== 12'sd0 || ready !== 1'b0) begin
                    miscompares++; $display("FAIL b2b_after_rst[%0d] got valid=%b conv=%0d ready=%b want 0/0/0", n, valid_out, conv_out, ready);
                end
            end
        end
        rst = 1'b0; valid_in = 1'b0;
        vectors++; if (pulses != 8) begin miscompares++; $display("FAIL b2b_pulses got %0d want 8", pulses); end
    endtask

    task automatic test_reload_inflight();
        load_weights(8'sd2, 25);
        window_all(8'd128);
        valid_in = 1'b1;
        tick();
        for (int i = 0; i < 25; i++) begin
            w_load = 1'b1;
            w_data = 8'sd1;
            tick();
            if (i == 1) begin
                vectors++; if (valid_out !== 1'b1 || conv_out !== 12'sd25) begin
                    miscompares++; $display("FAIL reload_old_weights got valid=%b conv=%0d want 1/25", valid_out, conv_out);
                end
            end else if (valid_out !== 1'b0) begin
                vectors++; miscompares++;
                $display("FAIL reload_ignored[%0d] got valid=%b want 0", i, valid_out);
            end else begin
                vectors++;
            end
        end
        w_load = 1'b0;
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reload_ready got %b want 1", ready); end
        tick();
        valid_in = 1'b0;
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reload_no_stray got %b want 0", valid_out); end
        tick(); tick();
        vectors++; if (valid_out !== 1'b1 || conv_out !== 12'sd12) begin
            miscompares++; $display("FAIL reload_new_weights got valid=%b conv=%0d want 1/12", valid_out, conv_out);
        end
    endtask

    initial begin
        test_reset();
        test_partial_load();
        test_basic();
        test_bias_timing();
        test_saturate();
        test_back_to_back();
        test_reload_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
